// File: rtl/clefia_diffusion.sv
// Iterative CLEFIA diffusion (M0 / M1 over GF(2^8), poly 0x11D).
// One output row is computed per cycle on a shared byte datapath.
module clefia_diffusion (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] din,
  input  logic        msel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] dout
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q;
  logic [1:0]  row_q;
  logic [31:0] x_q;
  logic        sel_q;
  logic [7:0]  y_q [4];
  logic        in_ready_q;
  logic        out_valid_q;

  // Multiply by 2 modulo z^8+z^4+z^3+z^2+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
  endfunction

  logic [7:0] x_b  [4];
  logic [7:0] op_b [4];

  // Entry (row, col) is base[row ^ col], so column k of the base row
  // multiplies x[row ^ k]; this turns both matrices into one fixed row.
  for (genvar gi = 0; gi < 4; gi++) begin : g_op
    assign x_b[gi]  = x_q[31-8*gi -: 8];
    assign op_b[gi] = x_b[row_q ^ 2'(gi)];
  end

  logic [7:0] m2_1, m4_1, m8_1;
  logic [7:0] m2_2, m4_2;
  logic [7:0] m2_3, m4_3, m8_3;
  logic [7:0] row_byte_d;

  assign m2_1 = xtime(op_b[1]);
  assign m4_1 = xtime(m2_1);
  assign m8_1 = xtime(m4_1);
  assign m2_2 = xtime(op_b[2]);
  assign m4_2 = xtime(m2_2);
  assign m2_3 = xtime(op_b[3]);
  assign m4_3 = xtime(m2_3);
  assign m8_3 = xtime(m4_3);

  // M0 base row {1,2,4,6}; M1 base row {1,8,2,A}.
  always_comb begin
    row_byte_d = op_b[0];
    if (sel_q) begin
      row_byte_d = op_b[0] ^ m8_1 ^ m2_2 ^ (m8_3 ^ m2_3);
    end else begin
      row_byte_d = op_b[0] ^ m2_1 ^ m4_2 ^ (m4_3 ^ m2_3);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      row_q       <= 2'd0;
      x_q         <= 32'h0;
      sel_q       <= 1'b0;
      y_q         <= '{default: 8'h00};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q        <= din;
            sel_q      <= msel;
            row_q      <= 2'd0;
            in_ready_q <= 1'b0;
            state_q    <= CALC;
          end
        end
        CALC: begin
          y_q[row_q] <= row_byte_d;
          row_q      <= row_q + 2'd1;
          if (row_q == 2'd3) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign dout      = {y_q[0], y_q[1], y_q[2], y_q[3]};

endmodule
